// File: rtl/gun_pos_ctrl_if.sv
// Joystick, mouse and recenter inputs plus the absolute gun position outputs of gun_pos_ctrl.
interface gun_pos_ctrl_if #(
  parameter int unsigned GUN_W = 6
);
  logic                    tick_4ms;
  logic                    joy_left;
  logic                    joy_right;
  logic                    joy_up;
  logic                    joy_down;
  logic                    mouse_valid;
  logic signed [8:0]       mouse_dx;
  logic signed [8:0]       mouse_dy;
  logic                    recenter;
  logic        [GUN_W-1:0] gun_h;
  logic        [GUN_W-1:0] gun_v;
  logic                    moving;

  modport master (
    output tick_4ms, joy_left, joy_right, joy_up, joy_down,
    output mouse_valid, mouse_dx, mouse_dy, recenter,
    input  gun_h, gun_v, moving
  );

  modport slave (
    input  tick_4ms, joy_left, joy_right, joy_up, joy_down,
    input  mouse_valid, mouse_dx, mouse_dy, recenter,
    output gun_h, gun_v, moving
  );
endinterface

// File: rtl/gun_pos_ctrl.sv
// Light-gun position generator: accelerating joystick stepping on 4 ms ticks plus
// relative mouse deltas, accumulated in 2-bit fixed point and saturated per axis.
module gun_pos_ctrl #(
  parameter int unsigned GUN_W       = 6,
  parameter int unsigned CENTER      = 32,
  parameter int unsigned INIT_DIV    = 3,
  parameter int unsigned MIN_DIV     = 1,
  parameter int unsigned ACCEL_STEPS = 4
) (
  input  logic           clk_12,
  input  logic           reset,
  gun_pos_ctrl_if.slave  bus
);
  localparam int unsigned POS_W = GUN_W + 2;
  // Wide enough for a full-scale position plus a joystick step plus the largest mouse delta.
  localparam int unsigned SUM_W = GUN_W + 5;
  localparam int unsigned MD_W  = 9;
  localparam int unsigned DIV_W = $clog2(INIT_DIV + 1);
  localparam int unsigned STP_W = $clog2(ACCEL_STEPS + 1);

  localparam logic        [DIV_W-1:0] DIV_INIT = DIV_W'(INIT_DIV);
  localparam logic        [DIV_W-1:0] DIV_MIN  = DIV_W'(MIN_DIV);
  localparam logic        [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic        [STP_W-1:0] STP_ACC  = STP_W'(ACCEL_STEPS);
  localparam logic        [STP_W-1:0] STP_LAST = STP_W'(ACCEL_STEPS - 1);
  localparam logic        [STP_W-1:0] STP_ONE  = STP_W'(1);
  localparam logic        [POS_W-1:0] POS_CTR  = POS_W'(CENTER * 4);
  localparam logic signed [SUM_W-1:0] SUM_MAX  = SUM_W'((1 << POS_W) - 1);
  localparam logic signed [SUM_W-1:0] STEP_P   = SUM_W'(4);
  localparam logic signed [SUM_W-1:0] STEP_N   = SUM_W'(-4);

  typedef enum logic {IDLE, MOVE} state_e;

  // Index 0 is the horizontal axis, index 1 the vertical axis.
  state_e                  state_q  [2];
  state_e                  state_d  [2];
  logic        [DIV_W-1:0] period_q [2];
  logic        [DIV_W-1:0] period_d [2];
  logic        [DIV_W-1:0] cnt_q    [2];
  logic        [DIV_W-1:0] cnt_d    [2];
  logic        [STP_W-1:0] steps_q  [2];
  logic        [STP_W-1:0] steps_d  [2];
  logic                    dir_q    [2];
  logic                    dir_d    [2];
  logic        [POS_W-1:0] pos_q    [2];
  logic        [POS_W-1:0] pos_d    [2];
  logic                    tick_r_q;
  logic                    moving_q;
  logic                    moving_d;

  logic                    tick_c;
  logic                    act_c    [2];
  logic                    dpos_c   [2];
  logic signed [MD_W-1:0]  md_c     [2];
  logic signed [SUM_W-1:0] jd_c     [2];
  logic signed [SUM_W-1:0] mext_c   [2];
  logic signed [SUM_W-1:0] sum_c    [2];

  // Per-axis stepping FSM, position accumulation and saturation.
  always_comb begin
    tick_c    = bus.tick_4ms & ~tick_r_q;
    act_c[0]  = bus.joy_left ^ bus.joy_right;
    dpos_c[0] = bus.joy_right;
    md_c[0]   = bus.mouse_dx;
    act_c[1]  = bus.joy_up ^ bus.joy_down;
    dpos_c[1] = bus.joy_down;
    md_c[1]   = bus.mouse_dy;

    for (int a = 0; a < 2; a++) begin
      state_d[a]  = state_q[a];
      period_d[a] = period_q[a];
      cnt_d[a]    = cnt_q[a];
      steps_d[a]  = steps_q[a];
      dir_d[a]    = dir_q[a];
      jd_c[a]     = '0;
      mext_c[a]   = '0;

      if (tick_c) begin
        if (!act_c[a]) begin
          state_d[a]  = IDLE;
          period_d[a] = DIV_INIT;
          cnt_d[a]    = DIV_INIT;
          steps_d[a]  = '0;
        end else if (state_q[a] == IDLE || dir_q[a] != dpos_c[a]) begin
          // Fresh press or reversal: immediate step, restart the slow pacing.
          jd_c[a]     = dpos_c[a] ? STEP_P : STEP_N;
          dir_d[a]    = dpos_c[a];
          period_d[a] = DIV_INIT;
          cnt_d[a]    = DIV_INIT;
          steps_d[a]  = STP_ONE;
          state_d[a]  = MOVE;
        end else if (cnt_q[a] == DIV_ONE) begin
          jd_c[a] = dpos_c[a] ? STEP_P : STEP_N;
          if (steps_q[a] >= STP_LAST && period_q[a] > DIV_MIN) begin
            period_d[a] = period_q[a] - DIV_ONE;
            cnt_d[a]    = period_q[a] - DIV_ONE;
            steps_d[a]  = '0;
          end else begin
            cnt_d[a]    = period_q[a];
            steps_d[a]  = (steps_q[a] >= STP_LAST) ? STP_ACC : steps_q[a] + STP_ONE;
          end
        end else begin
          cnt_d[a] = cnt_q[a] - DIV_ONE;
        end
      end

      if (bus.mouse_valid) begin
        mext_c[a] = {{(SUM_W - MD_W){md_c[a][MD_W-1]}}, md_c[a]};
      end

      sum_c[a] = $signed({{(SUM_W - POS_W){1'b0}}, pos_q[a]}) + jd_c[a] + mext_c[a];
      if (sum_c[a][SUM_W-1]) begin
        pos_d[a] = '0;
      end else if (sum_c[a] > SUM_MAX) begin
        pos_d[a] = '1;
      end else begin
        pos_d[a] = sum_c[a][POS_W-1:0];
      end

      if (bus.recenter) begin
        state_d[a]  = IDLE;
        period_d[a] = DIV_INIT;
        cnt_d[a]    = DIV_INIT;
        steps_d[a]  = '0;
        pos_d[a]    = POS_CTR;
      end
    end

    moving_d = (state_d[0] == MOVE) | (state_d[1] == MOVE);
  end

  always_ff @(posedge clk_12 or posedge reset) begin
    if (reset) begin
      tick_r_q <= 1'b0;
      moving_q <= 1'b0;
      for (int a = 0; a < 2; a++) begin
        state_q[a]  <= IDLE;
        period_q[a] <= DIV_INIT;
        cnt_q[a]    <= DIV_INIT;
        steps_q[a]  <= '0;
        dir_q[a]    <= 1'b0;
        pos_q[a]    <= POS_CTR;
      end
    end else begin
      tick_r_q <= bus.tick_4ms;
      moving_q <= moving_d;
      for (int a = 0; a < 2; a++) begin
        state_q[a]  <= state_d[a];
        period_q[a] <= period_d[a];
        cnt_q[a]    <= cnt_d[a];
        steps_q[a]  <= steps_d[a];
        dir_q[a]    <= dir_d[a];
        pos_q[a]    <= pos_d[a];
      end
    end
  end

  assign bus.gun_h  = pos_q[0][POS_W-1:2];
  assign bus.gun_v  = pos_q[1][POS_W-1:2];
  assign bus.moving = moving_q;
endmodule

// File: tb/tb_gun_pos_ctrl.sv
// Scoreboard bench for gun_pos_ctrl: stimulus queues expected positions, a negedge monitor checks them.
module tb_gun_pos_ctrl;
  logic clk_12 = 1'b0;
  logic reset  = 1'b1;

  always #5 clk_12 = ~clk_12;

  gun_pos_ctrl_if #(.GUN_W(6)) bus ();

  gun_pos_ctrl #(
    .GUN_W(6), .CENTER(32), .INIT_DIV(3), .MIN_DIV(1), .ACCEL_STEPS(4)
  ) dut (
    .clk_12(clk_12),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string name;
    int    h;
    int    v;
    int    mv;
    int    due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   ncyc   = 0;

  // Expected ramp of gun_h after each tick while right is held from 32.
  int ramp[19] = '{33, 33, 33, 34, 34, 34, 35, 35, 35, 36, 36, 37, 37, 38, 38, 39, 39, 40, 41};

  task automatic push_exp(input string name, input int h, input int v, input int mv);
    exp_t e;
    e.name = name;
    e.h    = h;
    e.v    = v;
    e.mv   = mv;
    e.due  = ncyc + 1;
    sb.push_back(e);
  endtask

  always @(negedge clk_12) begin
    ncyc = ncyc + 1;
    while (sb.size() > 0 && sb[0].due <= ncyc) begin
      mon_e  = sb.pop_front();
      checks = checks + 1;
      if (bus.gun_h !== 6'(mon_e.h) || bus.gun_v !== 6'(mon_e.v) || bus.moving !== 1'(mon_e.mv)) begin
        errors = errors + 1;
        $display("FAIL %s: got h=%0d v=%0d moving=%0d, want h=%0d v=%0d moving=%0d",
                 mon_e.name, bus.gun_h, bus.gun_v, bus.moving, mon_e.h, mon_e.v, mon_e.mv);
      end
    end
  end

  task automatic cyc();
    @(posedge clk_12);
    #1;
  endtask

  task automatic do_tick();
    bus.tick_4ms = 1'b1;
    cyc();
    bus.tick_4ms = 1'b0;
    cyc();
  endtask

  task automatic mouse(input int dx, input int dy);
    bus.mouse_valid = 1'b1;
    bus.mouse_dx    = 9'(dx);
    bus.mouse_dy    = 9'(dy);
    cyc();
    bus.mouse_valid = 1'b0;
    bus.mouse_dx    = '0;
    bus.mouse_dy    = '0;
  endtask

  task automatic recen();
    bus.recenter = 1'b1;
    cyc();
    bus.recenter = 1'b0;
    push_exp("recenter", 32, 32, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.tick_4ms    = 1'b0;
    bus.joy_left    = 1'b0;
    bus.joy_right   = 1'b0;
    bus.joy_up      = 1'b0;
    bus.joy_down    = 1'b0;
    bus.mouse_valid = 1'b0;
    bus.mouse_dx    = '0;
    bus.mouse_dy    = '0;
    bus.recenter    = 1'b0;
    repeat (2) @(posedge clk_12);
    #1;
    reset = 1'b0;
    cyc();
    push_exp("reset_state", 32, 32, 0);

    // A level held high yields a single tick.
    bus.joy_right = 1'b1;
    bus.tick_4ms  = 1'b1;
    repeat (100) cyc();
    bus.tick_4ms = 1'b0;
    cyc();
    push_exp("tick_level_once", 33, 32, 1);
    bus.joy_right = 1'b0;
    do_tick();
    push_exp("release_idle", 33, 32, 0);
    recen();

    // Acceleration ramp.
    bus.joy_right = 1'b1;
    for (int k = 0; k < 19; k++) begin
      do_tick();
      push_exp($sformatf("accel_t%0d", k), ramp[k], 32, 1);
    end
    bus.joy_right = 1'b0;
    do_tick();
    push_exp("accel_release", 41, 32, 0);
    recen();

    // Left edge saturation and conflicting directions.
    mouse(-124, 0);
    push_exp("mouse_to_one", 1, 32, 0);
    bus.joy_left = 1'b1;
    for (int k = 0; k < 4; k++) begin
      do_tick();
      push_exp($sformatf("left_sat_t%0d", k), 0, 32, 1);
    end
    bus.joy_left = 1'b0;
    do_tick();
    push_exp("left_release", 0, 32, 0);
    bus.joy_left  = 1'b1;
    bus.joy_right = 1'b1;
    for (int k = 0; k < 3; k++) begin
      do_tick();
      push_exp($sformatf("both_dirs_t%0d", k), 0, 32, 0);
    end
    bus.joy_left  = 1'b0;
    bus.joy_right = 1'b0;
    recen();

    // Mouse accumulation in quarter units and saturation.
    mouse(6, 0);
    push_exp("mouse_dx6_a", 33, 32, 0);
    mouse(6, 0);
    push_exp("mouse_dx6_b", 35, 32, 0);
    mouse(0, -200);
    push_exp("mouse_dy_neg_sat", 35, 0, 0);
    mouse(255, 0);
    push_exp("mouse_dx_pos_sat", 63, 0, 0);
    recen();

    // Joystick step and mouse delta in the same cycle.
    bus.joy_right   = 1'b1;
    bus.tick_4ms    = 1'b1;
    bus.mouse_valid = 1'b1;
    bus.mouse_dx    = 9'(6);
    cyc();
    bus.tick_4ms    = 1'b0;
    bus.mouse_valid = 1'b0;
    bus.mouse_dx    = '0;
    cyc();
    push_exp("step_plus_mouse", 34, 32, 1);
    bus.joy_right = 1'b0;
    do_tick();
    push_exp("step_plus_mouse_rel", 34, 32, 0);
    recen();

    // Recenter beats a same-cycle tick and mouse delta.
    bus.joy_down = 1'b1;
    for (int k = 0; k < 18; k++) do_tick();
    push_exp("down_to_40", 32, 40, 1);
    bus.recenter    = 1'b1;
    bus.tick_4ms    = 1'b1;
    bus.mouse_valid = 1'b1;
    bus.mouse_dx    = 9'(20);
    bus.mouse_dy    = 9'(20);
    cyc();
    bus.recenter    = 1'b0;
    bus.tick_4ms    = 1'b0;
    bus.mouse_valid = 1'b0;
    bus.mouse_dx    = '0;
    bus.mouse_dy    = '0;
    cyc();
    push_exp("recenter_priority", 32, 32, 0);
    do_tick();
    push_exp("down_reentry", 32, 33, 1);
    do_tick();
    do_tick();
    push_exp("down_init_pace", 32, 33, 1);
    do_tick();
    push_exp("down_third_tick", 32, 34, 1);

    // Asynchronous reset mid-move.
    bus.joy_right = 1'b1;
    do_tick();
    push_exp("pre_reset_move", 33, 34, 1);
    @(negedge clk_12);
    #2;
    reset = 1'b1;
    #1;
    checks = checks + 1;
    if (bus.gun_h !== 6'd32 || bus.gun_v !== 6'd32 || bus.moving !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL async_reset: got h=%0d v=%0d moving=%0d, want h=32 v=32 moving=0",
               bus.gun_h, bus.gun_v, bus.moving);
    end
    bus.joy_right = 1'b0;
    bus.joy_down  = 1'b0;
    cyc();
    reset = 1'b0;
    cyc();
    push_exp("post_reset", 32, 32, 0);

    repeat (3) @(negedge clk_12);
    #1;
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
      checks = checks + sb.size();
      errors = errors + sb.size();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
